sp_ram_be: RTL and testbench
============================

# sp_ram_be

Parametrised single-port synchronous RAM with per-byte write enables, selectable read-during-write behaviour, an optional output pipeline register and a built-in memory-clear sequencer. It is the generalised replacement for the plain `sp_ram` (data/addr/we/clk/q) in the design. The clear sequencer initialises the array after reset or on request, so downstream logic never reads uninitialised contents.

## Interface
Parameters:
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- ADDR_WIDTH, 10: address width; DEPTH = 2**ADDR_WIDTH.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- RDW_MODE, 0: read-during-write result; 0 = write-first (new word), 1 = read-first (old word).
- CLR_ON_RESET, 1: 1 runs the clear sequence automatically on reset release.
- CLR_VALUE, 0: DATA_WIDTH-wide word written by the clear sequence.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low. This is the only clock and the only reset.
- data  in  DATA_WIDTH  write data.
- addr  in  ADDR_WIDTH  word address.
- we  in  1  write strobe.
- be  in  DATA_WIDTH/8  byte enables, bit i controls data[8i+7:8i].
- re  in  1  read strobe.
- clr_req  in  1  single-cycle pulse that starts a clear sequence.
- q  out  DATA_WIDTH  read data.
- q_valid  out  1  single-cycle pulse marking a new q.
- busy  out  1  clear sequence in progress.

## Operation
- FSM states: IDLE and CLEAR. A CLEAR_CNT counter of ADDR_WIDTH bits runs the sequence.
- On reset release:
  - CLR_ON_RESET=1: enter CLEAR with CLR_CNT=0.
  - CLR_ON_RESET=0: enter IDLE.
- CLEAR state:
  - Each cycle writes CLR_VALUE to mem[CLR_CNT] with all bytes enabled, then increments CLR_CNT.
  - On the write to DEPTH-1, return to IDLE. The sequence takes exactly DEPTH cycles.
- IDLE, clr_req=1: enter CLEAR next cycle with CLR_CNT=0.
- clr_req while busy is ignored; the sequence does not restart.
- User we and re while busy are dropped:
  - no memory write, no q update, no q_valid.
- Write in IDLE with we=1: mem[addr] byte i takes data byte i wherever be[i]=1. Bytes with be[i]=0 are unchanged.
- we=1 with be all zero is a no-op.
- Read in IDLE with re=1: q is loaded from mem[addr].
- re=1 and we=1 in the same cycle:
  - RDW_MODE=0 returns the byte-merged new word.
  - RDW_MODE=1 returns the pre-write word.
- q holds its last value when no read occurs.
- The memory array itself is not reset. Only the clear sequence initialises it.

## Timing
- Reset values: q=0, q_valid=0, CLR_CNT=0.
  - busy=CLR_ON_RESET while rst_n is low; it stays high through the clear sequence.
- Read latency, with re sampled at edge n:
  - OUT_REG=0: q and q_valid update at edge n+1.
  - OUT_REG=1: q and q_valid update at edge n+2.
- Back-to-back reads (re held high) give one q_valid per cycle, in order, with no bubbles.
- Writes commit at the sampling edge. A read of the same address issued the next cycle returns the new word.
- busy rises on the edge after clr_req is sampled and falls on the edge after the DEPTH-1 write.
- A user access sampled in the cycle busy falls is accepted.
- Reads already in the OUT_REG pipeline when CLEAR starts still complete with their captured data.
- Address wrap: CLR_CNT DEPTH-1 ends the sequence; it never wraps to 0. User addresses carry no wrap logic.
- Reset asserted mid-clear:
  - outputs return to reset values immediately;
  - pipeline contents are discarded;
  - CLR_CNT resets, and the clear restarts from 0 on release when CLR_ON_RESET=1.

## Structure
- Shared package sp_ram_pkg holds:
  - the rdw_mode_e enum (WRITE_FIRST, READ_FIRST);
  - the clr_state_e enum (IDLE, CLEAR);
  - BYTE_W=8.
- Sub-module sp_ram_clr_fsm contains the FSM, CLR_CNT and busy. It outputs a write port (clr_we, clr_addr).
- The top level muxes the clear write port and the user port into the array. Byte-merge and RDW logic live in the top level.

## Test plan
Default parameters (32/10, OUT_REG=0, RDW_MODE=0, CLR_ON_RESET=1, CLR_VALUE=0) unless a line says otherwise.
- Reset release -> busy high for exactly 1024 cycles; reads at addr 0, 512 and 1023 then return 0x00000000.
- Write 0xAAAAAAAA to addr 5 with be=4'hF, then 0x11111111 with be=4'b0011, then read addr 5 -> q=0xAAAA1111 with q_valid one cycle after re.
- addr 0 holds 0xAAAAAAAA; apply we=1, re=1, data=0x11111111 in the same cycle -> q=0x11111111 with RDW_MODE=0 and q=0xAAAAAAAA with RDW_MODE=1; memory holds 0x11111111 afterwards in both modes.
- OUT_REG=1, re held for 4 cycles on addrs 1-4 preloaded 0x1..0x4 -> q_valid high for 4 consecutive cycles starting 2 cycles after the first re, with data 0x1, 0x2, 0x3, 0x4 in order.
- CLR_VALUE=0xDEADBEEF:
  - pulse clr_req in IDLE; issue we to addr 7 and a second clr_req during busy;
  - required: the write is dropped, busy stays high 1024 cycles, and addr 7 reads 0xDEADBEEF.
- Assert rst_n low when CLR_CNT=500:
  - q=0, q_valid=0 and busy=1 immediately;
  - after release, busy stays high for a full 1024 cycles.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the byte-enable single-port RAM slice.
package sp_ram_pkg;

   localparam int BYTE_W = 8;

   // Result returned when a read and a write hit the array in the same cycle.
   typedef enum logic {
      WRITE_FIRST = 1'b0,
      READ_FIRST  = 1'b1
   } rdw_mode_e;

   // Memory-clear sequencer states.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

endpackage

// File: rtl/sp_ram_clr_fsm.sv
// Memory-clear sequencer: walks every address once and presents a write port
// that the RAM top level gives priority over user traffic.
module sp_ram_clr_fsm
   import sp_ram_pkg::*;
#(
   parameter int ADDR_WIDTH   = 10,
   parameter int CLR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_req,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

   clr_state_e            state_r;
   logic [ADDR_WIDTH-1:0] clr_cnt_r;

   // State and address counter; the counter stops at the last address rather
   // than wrapping, and a request while clearing is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= (CLR_ON_RESET != 0) ? CLEAR : IDLE;
         clr_cnt_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (clr_req) begin
                  state_r   <= CLEAR;
                  clr_cnt_r <= '0;
               end
            end
            CLEAR: begin
               if (clr_cnt_r == CNT_LAST) begin
                  state_r <= IDLE;
               end else begin
                  clr_cnt_r <= clr_cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r   <= IDLE;
               clr_cnt_r <= '0;
            end
         endcase
      end
   end

   // Outputs come straight from the state register, so they are glitch-free.
   assign busy     = (state_r == CLEAR);
   assign clr_we   = (state_r == CLEAR);
   assign clr_addr = clr_cnt_r;

endmodule

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM with byte enables, selectable read-during-write
// result, optional output register and a built-in clear sequencer.
module sp_ram_be
   import sp_ram_pkg::*;
#(
   parameter int                  DATA_WIDTH   = 32,
   parameter int                  ADDR_WIDTH   = 10,
   parameter int                  OUT_REG      = 0,
   parameter int                  RDW_MODE     = 0,
   parameter int                  CLR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DATA_WIDTH-1:0]        data,
   input  logic [ADDR_WIDTH-1:0]        addr,
   input  logic                         we,
   input  logic [DATA_WIDTH/BYTE_W-1:0] be,
   input  logic                         re,
   input  logic                         clr_req,
   output logic [DATA_WIDTH-1:0]        q,
   output logic                         q_valid,
   output logic                         busy
);

   localparam int        DEPTH   = 2 ** ADDR_WIDTH;
   localparam int        NBYTES  = DATA_WIDTH / BYTE_W;
   localparam rdw_mode_e RDW_SEL = (RDW_MODE == 1) ? READ_FIRST : WRITE_FIRST;

   // Storage is deliberately not reset; the clear sequencer initialises it.
   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   logic                  busy_s;
   logic                  clr_we_s;
   logic [ADDR_WIDTH-1:0] clr_addr_s;
   logic                  user_wr_s;
   logic                  user_rd_s;
   logic                  wr_en_s;
   logic [DATA_WIDTH-1:0] old_word_s;
   logic [DATA_WIDTH-1:0] merged_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic [DATA_WIDTH-1:0] q1_r;
   logic                  v1_r;

   sp_ram_clr_fsm #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .CLR_ON_RESET (CLR_ON_RESET)
   ) u_clr_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .busy     (busy_s),
      .clr_we   (clr_we_s),
      .clr_addr (clr_addr_s)
   );

   // User traffic is dropped entirely while the array is being cleared.
   assign user_wr_s  = we & ~busy_s;
   assign user_rd_s  = re & ~busy_s;
   assign wr_en_s    = user_wr_s & (|be);
   assign old_word_s = mem_r[addr];
   assign busy       = busy_s;

   // Byte-merge the incoming data over the currently stored word.
   always_comb begin
      merged_s = old_word_s;
      for (int i = 0; i < NBYTES; i++) begin
         merged_s[i*BYTE_W +: BYTE_W] = be[i] ? data[i*BYTE_W +: BYTE_W]
                                              : old_word_s[i*BYTE_W +: BYTE_W];
      end
   end

   // Pick the word returned by a read that coincides with a write.
   always_comb begin
      if ((RDW_SEL == WRITE_FIRST) && user_wr_s) begin
         rd_word_s = merged_s;
      end else begin
         rd_word_s = old_word_s;
      end
   end

   // Array write port: the clear sequencer owns the array while busy.
   always_ff @(posedge clk) begin
      if (clr_we_s) begin
         mem_r[clr_addr_s] <= CLR_VALUE;
      end else if (wr_en_s) begin
         mem_r[addr] <= merged_s;
      end
   end

   // First read stage: capture data on an accepted read, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1_r <= '0;
         v1_r <= 1'b0;
      end else begin
         if (user_rd_s) begin
            q1_r <= rd_word_s;
         end
         v1_r <= user_rd_s;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] q2_r;
         logic                  v2_r;

         // Output stage; reads already captured finish even if a clear starts.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q2_r <= '0;
               v2_r <= 1'b0;
            end else begin
               if (v1_r) begin
                  q2_r <= q1_r;
               end
               v2_r <= v1_r;
            end
         end

         assign q       = q2_r;
         assign q_valid = v2_r;
      end else begin : g_no_out_reg
         assign q       = q1_r;
         assign q_valid = v1_r;
      end
   endgenerate

endmodule

// File: tb/tb_sp_ram_be.sv
// Scoreboard bench for sp_ram_be: instance A uses default parameters,
// instance B uses OUT_REG=1, RDW_MODE=1 and CLR_VALUE=0xDEADBEEF.
module tb_sp_ram_be;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [31:0] a_data, b_data;
   logic [9:0]  a_addr, b_addr;
   logic        a_we, b_we, a_re, b_re, a_clr_req, b_clr_req;
   logic [3:0]  a_be, b_be;
   logic [31:0] a_q, b_q;
   logic        a_q_valid, b_q_valid, a_busy, b_busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n;

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   exp_t exp_a[$];
   exp_t exp_b[$];
   exp_t ea, eb;

   sp_ram_be u_dut_a (
      .clk(clk), .rst_n(rst_n), .data(a_data), .addr(a_addr), .we(a_we),
      .be(a_be), .re(a_re), .clr_req(a_clr_req), .q(a_q), .q_valid(a_q_valid),
      .busy(a_busy)
   );

   sp_ram_be #(
      .OUT_REG(1), .RDW_MODE(1), .CLR_VALUE(32'hDEADBEEF)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .data(b_data), .addr(b_addr), .we(b_we),
      .be(b_be), .re(b_re), .clr_req(b_clr_req), .q(b_q), .q_valid(b_q_valid),
      .busy(b_busy)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor A: every q_valid must match the oldest expected read, on time.
   always @(negedge clk) begin
      if (a_q_valid === 1'b1) begin
         if (exp_a.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL a_unexpected_valid: actual q=0x%08h required no q_valid", a_q);
         end else begin
            ea = exp_a.pop_front();
            chk("a_q", a_q, ea.d);
            chk("a_latency_cycle", cyc, ea.due);
         end
      end
   end

   // Monitor B: same as A with the two-cycle output pipeline.
   always @(negedge clk) begin
      if (b_q_valid === 1'b1) begin
         if (exp_b.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL b_unexpected_valid: actual q=0x%08h required no q_valid", b_q);
         end else begin
            eb = exp_b.pop_front();
            chk("b_q", b_q, eb.d);
            chk("b_latency_cycle", cyc, eb.due);
         end
      end
   end

   task automatic a_write(input logic [9:0] ad, input logic [31:0] d, input logic [3:0] bb);
      a_addr = ad; a_data = d; a_be = bb; a_we = 1'b1;
      tick();
      a_we = 1'b0;
   endtask

   task automatic b_write(input logic [9:0] ad, input logic [31:0] d, input logic [3:0] bb);
      b_addr = ad; b_data = d; b_be = bb; b_we = 1'b1;
      tick();
      b_we = 1'b0;
   endtask

   task automatic a_read(input logic [9:0] ad, input logic [31:0] e);
      a_addr = ad; a_re = 1'b1;
      exp_a.push_back('{d: e, due: cyc + 1});
      tick();
      a_re = 1'b0;
   endtask

   task automatic b_read(input logic [9:0] ad, input logic [31:0] e);
      b_addr = ad; b_re = 1'b1;
      exp_b.push_back('{d: e, due: cyc + 2});
      tick();
      b_re = 1'b0;
   endtask

   task automatic a_rw(input logic [9:0] ad, input logic [31:0] d, input logic [3:0] bb,
                       input logic [31:0] e);
      a_addr = ad; a_data = d; a_be = bb; a_we = 1'b1; a_re = 1'b1;
      exp_a.push_back('{d: e, due: cyc + 1});
      tick();
      a_we = 1'b0; a_re = 1'b0;
   endtask

   task automatic b_rw(input logic [9:0] ad, input logic [31:0] d, input logic [3:0] bb,
                       input logic [31:0] e);
      b_addr = ad; b_data = d; b_be = bb; b_we = 1'b1; b_re = 1'b1;
      exp_b.push_back('{d: e, due: cyc + 2});
      tick();
      b_we = 1'b0; b_re = 1'b0;
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      a_data = 32'h0; a_addr = 10'd0; a_we = 1'b0; a_be = 4'h0; a_re = 1'b0; a_clr_req = 1'b0;
      b_data = 32'h0; b_addr = 10'd0; b_we = 1'b0; b_be = 4'h0; b_re = 1'b0; b_clr_req = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();

      // Reset values.
      chk("a_reset_q", a_q, 32'h0);
      chk("a_reset_q_valid", {31'd0, a_q_valid}, 32'd0);
      chk("a_reset_busy", {31'd0, a_busy}, 32'd1);
      chk("b_reset_q", b_q, 32'h0);
      chk("b_reset_q_valid", {31'd0, b_q_valid}, 32'd0);
      chk("b_reset_busy", {31'd0, b_busy}, 32'd1);

      // Clear after reset release lasts exactly DEPTH cycles.
      rst_n = 1'b1;
      n = 0;
      while (a_busy && n < 2000) begin
         tick();
         n++;
      end
      chk("a_busy_cycles_after_reset", n, 32'd1024);
      chk("b_busy_low_after_reset_clear", {31'd0, b_busy}, 32'd0);

      a_read(10'd0, 32'h0);
      a_read(10'd512, 32'h0);
      a_read(10'd1023, 32'h0);

      // Byte-enable merge and all-zero enable no-op.
      a_write(10'd5, 32'hAAAAAAAA, 4'hF);
      a_write(10'd5, 32'h11111111, 4'b0011);
      a_read(10'd5, 32'hAAAA1111);
      a_write(10'd5, 32'hFFFFFFFF, 4'b0000);
      a_read(10'd5, 32'hAAAA1111);

      // Read-during-write: write-first on A, read-first on B.
      a_write(10'd0, 32'hAAAAAAAA, 4'hF);
      a_rw(10'd0, 32'h11111111, 4'hF, 32'h11111111);
      a_read(10'd0, 32'h11111111);
      a_rw(10'd0, 32'h22222222, 4'b0100, 32'h11221111);
      a_read(10'd0, 32'h11221111);

      b_write(10'd0, 32'hAAAAAAAA, 4'hF);
      b_rw(10'd0, 32'h11111111, 4'hF, 32'hAAAAAAAA);
      b_read(10'd0, 32'h11111111);
      b_rw(10'd0, 32'h22222222, 4'b0100, 32'h11111111);
      b_read(10'd0, 32'h11221111);

      // Back-to-back reads through the output register.
      for (int i = 1; i <= 4; i++) b_write(10'(i), 32'(i), 4'hF);
      for (int i = 1; i <= 4; i++) begin
         b_addr = 10'(i);
         b_re = 1'b1;
         exp_b.push_back('{d: 32'(i), due: cyc + 2});
         tick();
      end
      b_re = 1'b0;
      repeat (3) tick();

      // Clear request on B together with a read that must still complete.
      b_clr_req = 1'b1; b_re = 1'b1; b_addr = 10'd4;
      exp_b.push_back('{d: 32'h4, due: cyc + 2});
      tick();
      b_clr_req = 1'b0; b_re = 1'b0;
      chk("b_busy_rise", {31'd0, b_busy}, 32'd1);
      n = 0;
      while (b_busy && n < 2000) begin
         if (n == 10) begin
            b_we = 1'b1; b_be = 4'hF; b_addr = 10'd7; b_data = 32'h12345678;
            b_clr_req = 1'b1; b_re = 1'b1;
         end else begin
            b_we = 1'b0; b_clr_req = 1'b0; b_re = 1'b0;
         end
         tick();
         n++;
      end
      b_we = 1'b0; b_clr_req = 1'b0; b_re = 1'b0;
      chk("b_busy_cycles_clr_req", n, 32'd1024);
      b_read(10'd7, 32'hDEADBEEF);
      b_read(10'd1, 32'hDEADBEEF);
      b_read(10'd0, 32'hDEADBEEF);
      repeat (3) tick();

      // Reset asserted with the clear counter at 500.
      a_clr_req = 1'b1;
      tick();
      a_clr_req = 1'b0;
      repeat (500) tick();
      rst_n = 1'b0;
      #1;
      chk("a_midclr_reset_q", a_q, 32'h0);
      chk("a_midclr_reset_q_valid", {31'd0, a_q_valid}, 32'd0);
      chk("a_midclr_reset_busy", {31'd0, a_busy}, 32'd1);
      chk("b_midclr_reset_q", b_q, 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      n = 0;
      while (a_busy && n < 2000) begin
         tick();
         n++;
      end
      chk("a_busy_cycles_after_midclr_reset", n, 32'd1024);
      a_read(10'd5, 32'h0);
      b_read(10'd5, 32'hDEADBEEF);
      repeat (4) tick();

      chk("a_scoreboard_drained", exp_a.size(), 32'd0);
      chk("b_scoreboard_drained", exp_b.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
